// File: rtl/bullet_controller.sv
// rtl/bullet_controller.sv - single-bullet launch, step and grid-collision sequencer
// Optional fire lockout after a shot ends: define BULLET_COOLDOWN_EN.
module bullet_controller #(
    parameter int STEP_CYCLES     = 4,
    parameter int CNT_W           = 24,
    parameter int COOLDOWN_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fire,
    input  logic [1:0]            colorSel,
    input  logic [3:0]            blockPos,
    input  logic [0:4][0:5][2:0]  ddState,
    input  logic                  halt,
    output logic [1:0]            bullState,
    output logic [3:0]            bullX,
    output logic [3:0]            bullY,
    output logic                  busy,
    output logic                  clearVld,
    output logic [2:0]            clearRow,
    output logic [2:0]            clearCol,
    output logic                  hitPulse,
    output logic                  missPulse,
    output logic                  escapePulse
);

    typedef enum logic [1:0] {S_IDLE, S_FLIGHT, S_COOL} state_t;

    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWN_CYCLES - 1);

    state_t           r_state, w_nxt_state;
    logic [CNT_W-1:0] r_cnt, w_nxt_cnt;
    logic [1:0]       w_nxt_bs;
    logic [3:0]       w_nxt_x, w_nxt_y;
    logic [2:0]       w_nxt_row, w_nxt_col;
    logic             w_nxt_clr, w_nxt_hit, w_nxt_miss, w_nxt_esc, w_end;
    logic [2:0]       w_row, w_col, w_cell, w_match;

    // Cell the bullet is about to enter; only meaningful in flight with bullY>0.
    assign w_row   = bullY[2:0] - 3'd1;
    assign w_col   = bullX[2:0];
    assign w_cell  = ddState[w_row][w_col];
    assign w_match = {1'b0, bullState} + 3'd3;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_bs    = bullState;
        w_nxt_x     = bullX;
        w_nxt_y     = bullY;
        w_nxt_row   = clearRow;
        w_nxt_col   = clearCol;
        w_nxt_clr   = 1'b0;
        w_nxt_hit   = 1'b0;
        w_nxt_miss  = 1'b0;
        w_nxt_esc   = 1'b0;
        w_end       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (fire && colorSel != 2'd0 && blockPos <= 4'd5) begin
                    w_nxt_state = S_FLIGHT;
                    w_nxt_cnt   = '0;
                    w_nxt_bs    = colorSel;
                    w_nxt_x     = blockPos;
                    w_nxt_y     = 4'd5;
                end
            end
            S_FLIGHT: begin
                if (r_cnt == STEP_LAST) begin
                    w_nxt_cnt = '0;
                    if (bullY == 4'd0) begin
                        w_nxt_esc = 1'b1;
                        w_end     = 1'b1;
                    end else if (w_cell == 3'd0) begin
                        w_nxt_y = {1'b0, w_row};
                    end else if (w_cell == w_match) begin
                        w_nxt_clr = 1'b1;
                        w_nxt_row = w_row;
                        w_nxt_col = w_col;
                        w_nxt_hit = 1'b1;
                        w_end     = 1'b1;
                    end else begin
                        w_nxt_miss = 1'b1;
                        w_end      = 1'b1;
                    end
                end else begin
                    w_nxt_cnt = r_cnt + 1'b1;
                end
            end
            S_COOL: begin
                if (r_cnt == COOL_LAST) begin
                    w_nxt_state = S_IDLE;
                    w_nxt_cnt   = '0;
                end else begin
                    w_nxt_cnt = r_cnt + 1'b1;
                end
            end
            default: w_nxt_state = S_IDLE;
        endcase
        if (w_end) begin
            w_nxt_bs  = 2'd0;
            w_nxt_x   = 4'd0;
            w_nxt_y   = 4'd0;
            w_nxt_cnt = '0;
`ifdef BULLET_COOLDOWN_EN
            w_nxt_state = S_COOL;
`else
            w_nxt_state = S_IDLE;
`endif
        end
        // Abort outranks launches and due steps; the shot vanishes without pulses.
        if (halt) begin
            w_nxt_state = S_IDLE;
            w_nxt_cnt   = '0;
            w_nxt_bs    = 2'd0;
            w_nxt_x     = 4'd0;
            w_nxt_y     = 4'd0;
            w_nxt_row   = clearRow;
            w_nxt_col   = clearCol;
            w_nxt_clr   = 1'b0;
            w_nxt_hit   = 1'b0;
            w_nxt_miss  = 1'b0;
            w_nxt_esc   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            bullState   <= 2'd0;
            bullX       <= 4'd0;
            bullY       <= 4'd0;
            busy        <= 1'b0;
            clearVld    <= 1'b0;
            clearRow    <= 3'd0;
            clearCol    <= 3'd0;
            hitPulse    <= 1'b0;
            missPulse   <= 1'b0;
            escapePulse <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_cnt       <= w_nxt_cnt;
            bullState   <= w_nxt_bs;
            bullX       <= w_nxt_x;
            bullY       <= w_nxt_y;
            busy        <= (w_nxt_state != S_IDLE);
            clearVld    <= w_nxt_clr;
            clearRow    <= w_nxt_row;
            clearCol    <= w_nxt_col;
            hitPulse    <= w_nxt_hit;
            missPulse   <= w_nxt_miss;
            escapePulse <= w_nxt_esc;
        end
    end

endmodule

// File: tb/tb_bullet_controller.sv
// tb/tb_bullet_controller.sv - randomized self-checking bench for bullet_controller
// Expectations come from a row-scan model of the shot; build with BULLET_COOLDOWN_EN to cover the lockout.
module tb_bullet_controller;

    localparam int S  = 4;
    localparam int CD = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 fire = 1'b0;
    logic [1:0]           colorSel = 2'd0;
    logic [3:0]           blockPos = 4'd0;
    logic [0:4][0:5][2:0] dd = '0;
    logic                 halt = 1'b0;
    logic [1:0]           bullState;
    logic [3:0]           bullX, bullY;
    logic                 busy, clearVld, hitPulse, missPulse, escapePulse;
    logic [2:0]           clearRow, clearCol;

    int n_chk = 0;
    int n_fail = 0;

    bullet_controller #(.STEP_CYCLES(S), .CNT_W(24), .COOLDOWN_CYCLES(CD)) dut (
        .clk(clk), .rst(rst), .fire(fire), .colorSel(colorSel), .blockPos(blockPos),
        .ddState(dd), .halt(halt), .bullState(bullState), .bullX(bullX), .bullY(bullY),
        .busy(busy), .clearVld(clearVld), .clearRow(clearRow), .clearCol(clearCol),
        .hitPulse(hitPulse), .missPulse(missPulse), .escapePulse(escapePulse)
    );

    always #5 clk = ~clk;

    // Model: scan the column upward from row 4; the first occupied row decides the shot.
    task automatic run_shot(input logic [1:0] col_c, input logic [3:0] pos, input bit tail);
        int end_k, end_t, hit_r, kind, p;
        logic [3:0] pulses_exp, pulses_got;
        p = int'(pos);
        end_k = 6; kind = 0; hit_r = 0;
        for (int r = 4; r >= 0; r--) begin
            if (dd[r][p] != 3'd0) begin
                end_k = 5 - r;
                hit_r = r;
                kind = (int'(dd[r][p]) == int'(col_c) + 3) ? 1 : 2;
                break;
            end
        end
        end_t = end_k * S;
        fire = 1'b1; colorSel = col_c; blockPos = pos;
        @(negedge clk);
        fire = 1'b0;
        n_chk++;
        if ({bullState, bullX, bullY, busy} !== {col_c, pos, 4'd5, 1'b1}) begin
            n_fail++;
            $display("FAIL launch: got bs=%0d x=%0d y=%0d busy=%0d, want bs=%0d x=%0d y=5 busy=1",
                     bullState, bullX, bullY, busy, col_c, pos);
        end
        for (int t = 1; t <= end_t; t++) begin
            fire = 1'($urandom_range(0, 1));
            colorSel = 2'($urandom);
            blockPos = 4'($urandom);
            @(negedge clk);
            pulses_got = {hitPulse, missPulse, escapePulse, clearVld};
            n_chk++;
            if (t < end_t) begin
                if ({bullState, bullX, bullY, pulses_got} !== {col_c, pos, 4'(5 - t / S), 4'b0000}) begin
                    n_fail++;
                    $display("FAIL flight t=%0d: got bs=%0d x=%0d y=%0d p=%b, want bs=%0d x=%0d y=%0d p=0000",
                             t, bullState, bullX, bullY, pulses_got, col_c, pos, 5 - t / S);
                end
            end else begin
                pulses_exp = (kind == 1) ? 4'b1001 : (kind == 2) ? 4'b0100 : 4'b0010;
                if ({bullState, bullX, bullY, pulses_got} !== {2'd0, 4'd0, 4'd0, pulses_exp}) begin
                    n_fail++;
                    $display("FAIL end t=%0d: got bs=%0d x=%0d y=%0d p=%b, want bs=0 x=0 y=0 p=%b",
                             t, bullState, bullX, bullY, pulses_got, pulses_exp);
                end
                if (kind == 1) begin
                    n_chk++;
                    if ({clearRow, clearCol} !== {3'(hit_r), 3'(p)}) begin
                        n_fail++;
                        $display("FAIL clear_cell: got r=%0d c=%0d, want r=%0d c=%0d", clearRow, clearCol, hit_r, p);
                    end
                end
                n_chk++;
`ifdef BULLET_COOLDOWN_EN
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL end_busy: got %0d want 1", busy);
                end
`else
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL end_busy: got %0d want 0", busy);
                end
`endif
            end
        end
        fire = 1'b0;
        if (tail) begin
            @(negedge clk);
            n_chk++;
            if ({hitPulse, missPulse, escapePulse, clearVld, bullState} !== 6'd0) begin
                n_fail++;
                $display("FAIL pulse_width: got p=%b bs=%0d, want p=0000 bs=0",
                         {hitPulse, missPulse, escapePulse, clearVld}, bullState);
            end
            if (kind == 1) begin
                n_chk++;
                if ({clearRow, clearCol} !== {3'(hit_r), 3'(p)}) begin
                    n_fail++;
                    $display("FAIL clear_hold: got r=%0d c=%0d, want r=%0d c=%0d", clearRow, clearCol, hit_r, p);
                end
            end
`ifdef BULLET_COOLDOWN_EN
            repeat (CD) @(negedge clk);
`endif
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_chk++;
        if ({bullState, bullX, bullY, busy, clearVld, clearRow, clearCol, hitPulse, missPulse, escapePulse} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_state: got bs=%0d x=%0d y=%0d busy=%0d, want all 0", bullState, bullX, bullY, busy);
        end
        rst = 1'b0;
        dd = '0;
        fire = 1'b1; colorSel = 2'd1; blockPos = 4'd2;
        @(negedge clk);
        fire = 1'b0;
        repeat (5) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        n_chk++;
        if ({bullState, bullX, bullY, busy, hitPulse, missPulse, escapePulse, clearVld} !== 15'd0) begin
            n_fail++;
            $display("FAIL async_reset: got bs=%0d x=%0d y=%0d busy=%0d, want all 0", bullState, bullX, bullY, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({bullState, busy} !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_idle: got bs=%0d busy=%0d, want 0 0", bullState, busy);
        end
        run_shot(2'd3, 4'd4, 1'b1);
    endtask

    task automatic test_escape;
        dd = '0;
        run_shot(2'd2, 4'd3, 1'b1);
    endtask

    task automatic test_hit;
        dd = '0;
        dd[2][1] = 3'd5;
        run_shot(2'd2, 4'd1, 1'b1);
    endtask

    task automatic test_miss;
        dd = '0;
        dd[4][0] = 3'd4;
        run_shot(2'd3, 4'd0, 1'b1);
        dd = '0;
        dd[1][5] = 3'd7;
        run_shot(2'd1, 4'd5, 1'b1);
    endtask

    task automatic test_illegal;
        logic [5:0] reqs [4];
        dd = '0;
        reqs[0] = {2'd1, 4'd7};
        reqs[1] = {2'd0, 4'd2};
        reqs[2] = {2'd2, 4'd6};
        reqs[3] = {2'd3, 4'd15};
        for (int i = 0; i < 4; i++) begin
            fire = 1'b1; colorSel = reqs[i][5:4]; blockPos = reqs[i][3:0];
            @(negedge clk);
            fire = 1'b0;
            n_chk++;
            if ({bullState, busy} !== 3'd0) begin
                n_fail++;
                $display("FAIL illegal_%0d: got bs=%0d busy=%0d, want 0 0", i, bullState, busy);
            end
        end
        halt = 1'b1; fire = 1'b1; colorSel = 2'd1; blockPos = 4'd1;
        @(negedge clk);
        halt = 1'b0; fire = 1'b0;
        n_chk++;
        if ({bullState, busy} !== 3'd0) begin
            n_fail++;
            $display("FAIL halt_launch: got bs=%0d busy=%0d, want 0 0", bullState, busy);
        end
    endtask

    task automatic test_halt_step;
        dd = '0;
        dd[4][0] = 3'd5;
        fire = 1'b1; colorSel = 2'd2; blockPos = 4'd0;
        @(negedge clk);
        fire = 1'b0;
        repeat (S - 1) @(negedge clk);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        n_chk++;
        if ({bullState, bullY, busy, hitPulse, missPulse, escapePulse, clearVld} !== 11'd0) begin
            n_fail++;
            $display("FAIL halt_step: got bs=%0d y=%0d busy=%0d p=%b, want all 0", bullState, bullY, busy,
                     {hitPulse, missPulse, escapePulse, clearVld});
        end
        fire = 1'b1; colorSel = 2'd1; blockPos = 4'd5;
        @(negedge clk);
        fire = 1'b0;
        n_chk++;
        if ({bullState, bullX, bullY, hitPulse, clearVld} !== {2'd1, 4'd5, 4'd5, 2'b00}) begin
            n_fail++;
            $display("FAIL halt_relaunch: got bs=%0d x=%0d y=%0d, want bs=1 x=5 y=5", bullState, bullX, bullY);
        end
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
    endtask

    task automatic test_back_to_back;
        dd = '0;
        run_shot(2'd1, 4'd2, 1'b0);
        fire = 1'b1; colorSel = 2'd3; blockPos = 4'd4;
`ifdef BULLET_COOLDOWN_EN
        for (int k = 1; k <= CD; k++) begin
            @(negedge clk);
            n_chk++;
            if ({bullState, busy} !== {2'd0, (k < CD)}) begin
                n_fail++;
                $display("FAIL cooldown_%0d: got bs=%0d busy=%0d, want bs=0 busy=%0d", k, bullState, busy, k < CD);
            end
        end
`endif
        @(negedge clk);
        fire = 1'b0;
        n_chk++;
        if ({bullState, bullX, bullY, busy} !== {2'd3, 4'd4, 4'd5, 1'b1}) begin
            n_fail++;
            $display("FAIL back_to_back: got bs=%0d x=%0d y=%0d busy=%0d, want bs=3 x=4 y=5 busy=1",
                     bullState, bullX, bullY, busy);
        end
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
    endtask

    task automatic test_random;
        for (int n = 0; n < 20; n++) begin
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 6; c++)
                    dd[r][c] = ($urandom_range(0, 9) < 7) ? 3'd0 : 3'($urandom_range(1, 7));
            run_shot(2'($urandom_range(1, 3)), 4'($urandom_range(0, 5)), 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_escape();
        test_hit();
        test_miss();
        test_illegal();
        test_halt_step();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
